urna_multicandidato: RTL and testbench

Parametrised successor of the four-candidate electronic ballot box: accepts a vote as a sequence of BCD digits, compares the completed code against a table of `NUM_CAND` candidate codes, and increments the matching saturating tally, or the null tally. Adds correction (`Corrige`), blank votes, a total counter and a `Done` pulse. It sits between the keypad debouncer and the result display/readout logic.

---
 rtl/urna_pkg.sv | 16 +
 rtl/urna_sat_counter.sv | 19 +
 rtl/urna_multicandidato.sv | 156 +++++++++++++++
 tb/tb_urna_multicandidato.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/urna_pkg.sv
// Shared types and constants for the multi-candidate ballot box.
package urna_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTER,
        FULL,
        COMMIT
    } state_t;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    localparam logic [63:0] DEFAULT_CODES = {16'h3494, 16'h3485, 16'h3472, 16'h3504};

endpackage

// File: rtl/urna_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module urna_sat_counter #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/urna_multicandidato.sv
// BCD-keyed multi-candidate ballot box with saturating tallies, correction and commit pulse.
// Define URNA_BRANCO_EN to count blank votes (Finish with no digits keyed).
module urna_multicandidato
    import urna_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int DIGITS   = 4,
    parameter int CNT_W    = 8,
    parameter logic [NUM_CAND*DIGITS*BCD_W-1:0] CAND_CODES = DEFAULT_CODES
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [BCD_W-1:0]          Digit,
    input  logic                      Valid,
    input  logic                      Finish,
    input  logic                      Corrige,
    output logic [NUM_CAND*CNT_W-1:0] Votes,
    output logic [CNT_W-1:0]          Nulo,
    output logic [CNT_W-1:0]          Branco,
    output logic [CNT_W-1:0]          Total,
    output logic                      Status,
    output logic                      Done
);

    localparam int BUF_W = DIGITS * BCD_W;
    localparam int CW    = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);
`ifdef URNA_BRANCO_EN
    localparam bit BRANCO_EN = 1'b1;
`else
    localparam bit BRANCO_EN = 1'b0;
`endif

    state_t             state, state_nxt;
    logic               valid_q, finish_q, corrige_q;
    logic [BCD_W-1:0]   hold;
    logic [BUF_W-1:0]   buffer, buffer_nxt;
    logic [CW-1:0]      count, count_nxt;
    logic               invalid, invalid_nxt;
    logic               status_r, done_r;
    logic               valid_fall, finish_rise, corrige_rise;
    logic               clear, accept, in_commit, hit;
    logic [NUM_CAND-1:0] match;

    assign valid_fall   = valid_q & ~Valid;
    assign finish_rise  = Finish & ~finish_q;
    assign corrige_rise = Corrige & ~corrige_q;
    assign in_commit    = (state == COMMIT);

    // COMMIT always returns to IDLE but still takes a digit released during it.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        accept    = 1'b0;
        if (state == COMMIT) begin
            state_nxt = IDLE;
            clear     = 1'b1;
            accept    = valid_fall;
        end else if (corrige_rise) begin
            state_nxt = IDLE;
            clear     = 1'b1;
        end else if (finish_rise && (BRANCO_EN || (count != '0))) begin
            state_nxt = COMMIT;
        end else if (valid_fall && (state != FULL)) begin
            accept = 1'b1;
        end

        buffer_nxt  = clear ? '0 : buffer;
        count_nxt   = clear ? '0 : count;
        invalid_nxt = clear ? 1'b0 : invalid;
        if (accept) begin
            buffer_nxt  = (buffer_nxt << BCD_W) | BUF_W'(hold);
            count_nxt   = count_nxt + CW'(1);
            invalid_nxt = invalid_nxt | (hold > BCD_W'(BCD_MAX));
            state_nxt   = (count_nxt == FULL_CNT) ? FULL : ENTER;
        end
    end

    // Lowest-index candidate wins when codes are duplicated.
    always_comb begin
        match = '0;
        hit   = 1'b0;
        if ((count == FULL_CNT) && !invalid) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (!hit && (buffer == CAND_CODES[(NUM_CAND-1-i)*BUF_W +: BUF_W])) begin
                    match[i] = 1'b1;
                    hit      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            finish_q  <= 1'b0;
            corrige_q <= 1'b0;
            hold      <= '0;
            buffer    <= '0;
            count     <= '0;
            invalid   <= 1'b0;
            status_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_nxt;
            valid_q   <= Valid;
            finish_q  <= Finish;
            corrige_q <= Corrige;
            if (Valid) hold <= Digit;
            buffer    <= buffer_nxt;
            count     <= count_nxt;
            invalid   <= invalid_nxt;
            status_r  <= (state_nxt == ENTER) || (state_nxt == FULL);
            done_r    <= in_commit;
        end
    end

    assign Status = status_r;
    assign Done   = done_r;

    for (genvar i = 0; i < NUM_CAND; i++) begin : g_vote
        urna_sat_counter #(.W(CNT_W)) u_vote (
            .Clock (Clock),
            .Reset (Reset),
            .inc   (in_commit && match[i]),
            .count (Votes[i*CNT_W +: CNT_W])
        );
    end

    urna_sat_counter #(.W(CNT_W)) u_nulo (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (in_commit && !hit && (count != '0)),
        .count (Nulo)
    );

    urna_sat_counter #(.W(CNT_W)) u_total (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (in_commit),
        .count (Total)
    );

`ifdef URNA_BRANCO_EN
    urna_sat_counter #(.W(CNT_W)) u_branco (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (in_commit && (count == '0)),
        .count (Branco)
    );
`else
    assign Branco = '0;
`endif

endmodule

// File: tb/tb_urna_multicandidato.sv
// Bench for urna_multicandidato: two instances (8-bit and 2-bit tallies) against a vote-level model.
`timescale 1ns/1ps
module tb_urna_multicandidato;

    localparam int NC = 4;
`ifdef URNA_BRANCO_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic       Valid = 1'b0;
    logic       Finish = 1'b0;
    logic       Corrige = 1'b0;
    logic [3:0] Digit = 4'd0;

    logic [NC*8-1:0] votes_a;
    logic [7:0]      nulo_a, branco_a, total_a;
    logic            status_a, done_a;
    logic [NC*2-1:0] votes_b;
    logic [1:0]      nulo_b, branco_b, total_b;
    logic            status_b, done_b;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    bit run_done = 1'b0;

    // Vote-level model: keyed digits as a queue, raw (unsaturated) tallies.
    int   codes[NC] = '{3494, 3485, 3472, 3504};
    int   mv[NC];
    int   mn = 0, mb = 0, mt = 0;
    bit   mdone = 1'b0, mcommit = 1'b0, mbad = 1'b0;
    int   mdig[$];
    bit   pv = 1'b0, pf = 1'b0, pc = 1'b0;
    logic [3:0] ph = 4'd0;
    int   mval, mwin;
    bit   vfall, frise, crise;

    urna_multicandidato #(.NUM_CAND(NC), .DIGITS(4), .CNT_W(8)) dut (
        .Clock(Clock), .Reset(Reset), .Digit(Digit), .Valid(Valid), .Finish(Finish),
        .Corrige(Corrige), .Votes(votes_a), .Nulo(nulo_a), .Branco(branco_a),
        .Total(total_a), .Status(status_a), .Done(done_a)
    );

    urna_multicandidato #(.NUM_CAND(NC), .DIGITS(4), .CNT_W(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .Digit(Digit), .Valid(Valid), .Finish(Finish),
        .Corrige(Corrige), .Votes(votes_b), .Nulo(nulo_b), .Branco(branco_b),
        .Total(total_b), .Status(status_b), .Done(done_b)
    );

    always #5 Clock = ~Clock;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear;
        for (int i = 0; i < NC; i++) mv[i] = 0;
        mn = 0; mb = 0; mt = 0;
        mdone = 1'b0; mcommit = 1'b0; mbad = 1'b0;
        mdig.delete();
        pv = 1'b0; pf = 1'b0; pc = 1'b0; ph = 4'd0;
    endtask

    task automatic model_accept;
        mdig.push_back(int'(ph));
        if (ph > 4'd9) mbad = 1'b1;
    endtask

    task automatic model_commit;
        if (mdig.size() == 0) begin
            mb++;
        end else begin
            mval = 0;
            mwin = -1;
            foreach (mdig[j]) mval = mval * 10 + mdig[j];
            if (!mbad && mdig.size() == 4)
                for (int i = NC - 1; i >= 0; i--) if (codes[i] == mval) mwin = i;
            if (mwin >= 0) mv[mwin]++;
            else mn++;
        end
        mt++;
        mdone = 1'b1;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge Clock or negedge Reset);
            if (!Reset) begin
                model_clear();
            end else begin
                vfall = pv && !Valid;
                frise = Finish && !pf;
                crise = Corrige && !pc;
                mdone = 1'b0;
                if (mcommit) begin
                    model_commit();
                    mdig.delete();
                    mbad = 1'b0;
                    mcommit = 1'b0;
                    if (vfall) model_accept();
                end else if (crise) begin
                    mdig.delete();
                    mbad = 1'b0;
                end else if (frise && (BR || mdig.size() > 0)) begin
                    mcommit = 1'b1;
                end else if (vfall && mdig.size() < 4) begin
                    model_accept();
                end
                if (Valid) ph = Digit;
                pv = Valid; pf = Finish; pc = Corrige;
            end
        end
    end

    task automatic cmp_all;
        for (int i = 0; i < NC; i++) begin
            chk("votes_a", votes_a[i*8 +: 8], sat(mv[i], 255));
            chk("votes_b", votes_b[i*2 +: 2], sat(mv[i], 3));
        end
        chk("nulo_a", nulo_a, sat(mn, 255));
        chk("nulo_b", nulo_b, sat(mn, 3));
        chk("branco_a", branco_a, BR ? sat(mb, 255) : 0);
        chk("branco_b", branco_b, BR ? sat(mb, 3) : 0);
        chk("total_a", total_a, sat(mt, 255));
        chk("total_b", total_b, sat(mt, 3));
        chk("status_a", status_a, (!mcommit && mdig.size() > 0));
        chk("status_b", status_b, (!mcommit && mdig.size() > 0));
        chk("done_a", done_a, mdone);
        chk("done_b", done_b, mdone);
    endtask

    initial forever begin
        @(negedge Clock);
        if (!run_done) cmp_all();
    end

    initial forever begin
        @(negedge Clock);
        if (done_a === 1'b1) done_cnt++;
    end

    task automatic tick;
        @(posedge Clock);
        #2;
    endtask

    task automatic key(input logic [3:0] d);
        Digit = d; Valid = 1'b1; tick();
        Valid = 1'b0; tick(); tick();
    endtask

    task automatic fin;
        Finish = 1'b1; tick();
        Finish = 1'b0; tick(); tick(); tick();
    endtask

    task automatic cor;
        Corrige = 1'b1; tick();
        Corrige = 1'b0; tick(); tick();
    endtask

    task automatic vote4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        key(a); key(b); key(c); key(d); fin();
    endtask

    initial begin
        tick(); tick(); tick();
        chk("rst_votes", votes_a, 0);
        chk("rst_total", total_a, 0);
        chk("rst_status", status_a, 0);
        Reset = 1'b1;
        tick();

        vote4(4'd3, 4'd4, 4'd9, 4'd4);
        chk("v0_first", votes_a[7:0], 1);
        chk("total_first", total_a, 1);
        chk("done_first", done_cnt, 1);
        chk("status_after", status_a, 0);

        vote4(4'd3, 4'd5, 4'd0, 4'd4);
        chk("v3_3504", votes_a[31:24], 1);
        key(4'd3); key(4'd0); fin();
        chk("nulo_partial", nulo_a, 1);

        key(4'd3); key(4'd4); key(4'd7); cor();
        chk("status_cor", status_a, 0);
        vote4(4'd3, 4'd4, 4'd8, 4'd5);
        chk("v1_3485", votes_a[15:8], 1);
        chk("nulo_kept", nulo_a, 1);
        key(4'd3); key(4'd4); key(4'd7); key(4'd2); key(4'd6); fin();
        chk("v2_3472", votes_a[23:16], 1);
        chk("total_five", total_a, 5);

        key(4'd3); key(4'd4);
        chk("status_mid", status_a, 1);
        key(4'hC); key(4'd4); fin();
        chk("nulo_invalid", nulo_a, 2);

        fin();
        chk("branco_empty", branco_a, BR ? 1 : 0);
        chk("total_empty", total_a, BR ? 7 : 6);
        chk("done_empty", done_cnt, BR ? 7 : 6);

        for (int n = 0; n < 5; n++) vote4(4'd3, 4'd4, 4'd9, 4'd4);
        chk("v0_wide", votes_a[7:0], 6);
        chk("v0_sat", votes_b[1:0], 3);
        chk("total_sat", total_b, 3);
        chk("total_wide", total_a, BR ? 12 : 11);

        key(4'd3); key(4'd4);
        Reset = 1'b0; tick(); tick();
        chk("rst_mid_votes", votes_a, 0);
        chk("rst_mid_nulo", nulo_a, 0);
        chk("rst_mid_total", total_a, 0);
        chk("rst_mid_status", status_a, 0);
        Reset = 1'b1; tick();

        key(4'd3); key(4'd4);
        Finish = 1'b1; Corrige = 1'b1; tick();
        Finish = 1'b0; Corrige = 1'b0; tick(); tick(); tick();
        chk("both_total", total_a, 0);
        chk("both_status", status_a, 0);

        key(4'd3); key(4'd4); key(4'd9);
        Digit = 4'd7; Valid = 1'b1; tick();
        Digit = 4'd4; tick(); tick();
        Valid = 1'b0; tick(); tick();
        fin();
        chk("settle_v0", votes_a[7:0], 1);

        key(4'd3); key(4'd4); key(4'd9); key(4'd4);
        Finish = 1'b1; Digit = 4'd3; Valid = 1'b1; tick();
        Finish = 1'b0; Valid = 1'b0; tick(); tick(); tick();
        chk("commit_v0", votes_a[7:0], 2);
        chk("carry_status", status_a, 1);
        key(4'd4); key(4'd9); key(4'd4); fin();
        chk("carry_v0", votes_a[7:0], 3);
        chk("carry_total", total_a, 3);
        chk("done_final", done_cnt, BR ? 15 : 14);

        run_done = 1'b1;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
